// File: rtl/pushbutton_conditioner.sv
// pushbutton_conditioner
//   Input stage for the CPU pushbuttons port. Each raw button line is passed
//   through a 2-FF synchroniser and then debounced by its own small FSM and
//   counter; a new level is accepted only after DEBOUNCE_CYCLES consecutive
//   synchronised samples at that value.
//
//   Ports
//     clock        system clock, rising edge
//     reset        synchronous, active-low reset
//     raw_buttons  asynchronous button inputs, 1 = pressed
//     ack          per-bit clear of the sticky press flag (PB_STICKY_EN only)
//     buttons_out  debounced level, or sticky press flag with PB_STICKY_EN
//     press_pulse  one-cycle pulse on each accepted 0->1 transition
//     busy         high while any bit is part-way through a debounce
//
//   Build option
//     PB_STICKY_EN  when defined, buttons_out holds a per-bit flag that is set
//                   by press_pulse and cleared by ack (set wins).

module pushbutton_conditioner #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_buttons,
    input  logic [WIDTH-1:0] ack,
    output logic [WIDTH-1:0] buttons_out,
    output logic [WIDTH-1:0] press_pulse,
    output logic             busy
);

    typedef enum logic [1:0] {
        STABLE_LOW,
        WAIT_HIGH,
        STABLE_HIGH,
        WAIT_LOW
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q, s2_q;
    state_t           state_q [WIDTH];
    state_t           state_d [WIDTH];
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [CNT_W-1:0] cnt_d   [WIDTH];
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] pulse_q, pulse_d;
    logic             busy_q, busy_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            level_q <= '0;
            pulse_q <= '0;
            busy_q  <= 1'b0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                state_q[i] <= STABLE_LOW;
                cnt_q[i]   <= '0;
            end
        end else begin
            s1_q    <= raw_buttons;
            s2_q    <= s1_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        level_d = level_q;
        pulse_d = '0;
        busy_d  = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                STABLE_LOW: begin
                    if (s2_q[i]) begin
                        state_d[i] = WAIT_HIGH;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        cnt_d[i]   = '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!s2_q[i]) begin
                        state_d[i] = STABLE_LOW;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = STABLE_HIGH;
                        level_d[i] = 1'b1;
                        pulse_d[i] = 1'b1;
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_ONE;
                    end
                end
                STABLE_HIGH: begin
                    if (!s2_q[i]) begin
                        state_d[i] = WAIT_LOW;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                WAIT_LOW: begin
                    if (s2_q[i]) begin
                        state_d[i] = STABLE_HIGH;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = STABLE_LOW;
                        level_d[i] = 1'b0;
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = STABLE_LOW;
                    cnt_d[i]   = '0;
                end
            endcase
            // busy follows the next state so it changes on the same edge as the FSM
            if (state_d[i] == WAIT_HIGH || state_d[i] == WAIT_LOW) begin
                busy_d = 1'b1;
            end
        end
    end

    assign press_pulse = pulse_q;
    assign busy        = busy_q;

`ifdef PB_STICKY_EN
    logic [WIDTH-1:0] sticky_q;

    // Set is taken from the visible press_pulse, so an ack in the pulse cycle loses
    always_ff @(posedge clock) begin
        if (!reset) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= pulse_q | (sticky_q & ~ack);
        end
    end

    assign buttons_out = sticky_q;
`else
    logic unused_ack;

    assign unused_ack  = ^ack;
    assign buttons_out = level_q;
`endif

endmodule

// File: tb/tb_pushbutton_conditioner.sv
module tb_pushbutton_conditioner;

    localparam int W = 4;
    localparam int D = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] raw_buttons = '0;
    logic [W-1:0] ack = '0;
    logic [W-1:0] buttons_out;
    logic [W-1:0] press_pulse;
    logic         busy;

    pushbutton_conditioner #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D),
        .CNT_W(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .raw_buttons(raw_buttons),
        .ack(ack),
        .buttons_out(buttons_out),
        .press_pulse(press_pulse),
        .busy(busy)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;

`ifdef PB_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    // Reference model: synchroniser as a sample history, debounce as a count
    // of consecutive synchronised samples that disagree with the accepted level.
    logic [W-1:0] m_s1, m_s2, m_lvl, m_pulse, m_stk;
    logic         m_busy;
    int           m_run [W];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic [W-1:0] raw, input logic [W-1:0] a);
        if (!rst) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pulse = '0; m_stk = '0; m_busy = 1'b0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            m_stk   = m_pulse | (m_stk & ~a);
            m_pulse = '0;
            m_busy  = 1'b0;
            for (int i = 0; i < W; i++) begin
                if (m_s2[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_lvl[i]   = m_s2[i];
                        m_pulse[i] = m_s2[i];
                        m_run[i]   = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                if (m_run[i] != 0) m_busy = 1'b1;
            end
            m_s2 = m_s1;
            m_s1 = raw;
        end
    endtask

    // Drive inputs for one clock, advance the model, compare just after the edge
    task automatic tick(input logic rst, input logic [W-1:0] raw, input logic [W-1:0] a);
        reset = rst;
        raw_buttons = raw;
        ack = a;
        @(posedge clock);
        model_edge(rst, raw, a);
        #1;
        check("model_out", buttons_out, STICKY ? m_stk : m_lvl);
        check("model_pulse", press_pulse, m_pulse);
        check("model_busy", {3'b000, busy}, {3'b000, m_busy});
    endtask

    typedef struct {
        logic         rst;
        logic [W-1:0] raw;
        logic [W-1:0] out;
        logic [W-1:0] pulse;
        logic         bsy;
    } vec_t;

    vec_t tbl [16];

    int           first_t, pcount, bcount;
    logic [W-1:0] pval, seen_out;
    logic [W-1:0] bounce [10];
    logic [W-1:0] r;

    initial begin
        model_edge(1'b0, '0, '0);

        // reset with raw=F held, then release; level accepted on the 6th released edge
        for (int i = 0; i < 3; i++) tbl[i] = '{1'b0, 4'hF, 4'h0, 4'h0, 1'b0};
        tbl[3]  = '{1'b1, 4'hF, 4'h0, 4'h0, 1'b0};
        tbl[4]  = '{1'b1, 4'hF, 4'h0, 4'h0, 1'b0};
        tbl[5]  = '{1'b1, 4'hF, 4'h0, 4'h0, 1'b1};
        tbl[6]  = '{1'b1, 4'hF, 4'h0, 4'h0, 1'b1};
        tbl[7]  = '{1'b1, 4'hF, 4'h0, 4'h0, 1'b1};
        tbl[8]  = '{1'b1, 4'hF, STICKY ? 4'h0 : 4'hF, 4'hF, 1'b0};
        tbl[9]  = '{1'b1, 4'hF, 4'hF, 4'h0, 1'b0};
        // release: no pulse, level drops after the same latency
        tbl[10] = '{1'b1, 4'h0, 4'hF, 4'h0, 1'b0};
        tbl[11] = '{1'b1, 4'h0, 4'hF, 4'h0, 1'b0};
        tbl[12] = '{1'b1, 4'h0, 4'hF, 4'h0, 1'b1};
        tbl[13] = '{1'b1, 4'h0, 4'hF, 4'h0, 1'b1};
        tbl[14] = '{1'b1, 4'h0, 4'hF, 4'h0, 1'b1};
        tbl[15] = '{1'b1, 4'h0, STICKY ? 4'hF : 4'h0, 4'h0, 1'b0};

        for (int i = 0; i < 16; i++) begin
            tick(tbl[i].rst, tbl[i].raw, 4'h0);
            check($sformatf("tbl%0d_out", i), buttons_out, tbl[i].out);
            check($sformatf("tbl%0d_pulse", i), press_pulse, tbl[i].pulse);
            check($sformatf("tbl%0d_busy", i), {3'b000, busy}, {3'b000, tbl[i].bsy});
        end
        tick(1'b1, 4'h0, 4'hF);

        // clean press on bit 0
        first_t = 0; pcount = 0; pval = '0; seen_out = '0;
        for (int t = 1; t <= 9; t++) begin
            tick(1'b1, 4'h1, 4'h0);
            if (press_pulse != 0) begin
                pcount++;
                if (first_t == 0) begin first_t = t; pval = press_pulse; seen_out = buttons_out; end
            end
        end
        check("press_edge", 4'(first_t), 4'd6);
        check("press_val", pval, 4'h1);
        check("press_width", 4'(pcount), 4'd1);
        if (!STICKY) check("press_level", seen_out, 4'h1);
        for (int t = 0; t < 8; t++) tick(1'b1, 4'h0, 4'hF);

        // glitch on bit 2: two cycles high
        pcount = 0; bcount = 0; seen_out = '0;
        for (int t = 0; t < 10; t++) begin
            tick(1'b1, (t < 2) ? 4'h4 : 4'h0, 4'h0);
            if (press_pulse != 0) pcount++;
            if (busy) bcount++;
            seen_out = seen_out | buttons_out;
        end
        check("glitch_pulse", 4'(pcount), 4'd0);
        check("glitch_busy", 4'(bcount), 4'd2);
        check("glitch_out", seen_out, 4'h0);

        // bounce on bit 1
        bounce = '{4'h2, 4'h0, 4'h2, 4'h2, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2};
        first_t = 0; pcount = 0;
        for (int t = 1; t <= 16; t++) begin
            tick(1'b1, (t <= 10) ? bounce[t-1] : 4'h2, 4'h0);
            if (press_pulse != 0) begin
                pcount++;
                if (first_t == 0) first_t = t;
            end
        end
        check("bounce_count", 4'(pcount), 4'd1);
        check("bounce_edge", 4'(first_t), 4'd11);
        for (int t = 0; t < 8; t++) tick(1'b1, 4'h0, 4'hF);

        // multi-bit: A settles, then 5 swaps every bit on one edge
        for (int t = 0; t < 8; t++) tick(1'b1, 4'hA, 4'h0);
        first_t = 0; pcount = 0; pval = '0; seen_out = '0;
        for (int t = 1; t <= 9; t++) begin
            tick(1'b1, 4'h5, 4'h0);
            if (t == 5 && !STICKY) check("multi_before", buttons_out, 4'hA);
            if (press_pulse != 0) begin
                pcount++;
                if (first_t == 0) begin first_t = t; pval = press_pulse; seen_out = buttons_out; end
            end
        end
        check("multi_edge", 4'(first_t), 4'd6);
        check("multi_pulse", pval, 4'h5);
        check("multi_width", 4'(pcount), 4'd1);
        if (!STICKY) check("multi_out", seen_out, 4'h5);
        for (int t = 0; t < 8; t++) tick(1'b1, 4'h0, 4'hF);

`ifdef PB_STICKY_EN
        for (int t = 0; t < 7; t++) tick(1'b1, 4'h8, 4'h0);
        for (int t = 0; t < 8; t++) tick(1'b1, 4'h0, 4'h0);
        check("sticky_hold", buttons_out, 4'h8);
        tick(1'b1, 4'h0, 4'h8);
        check("sticky_ack", buttons_out, 4'h0);
        first_t = 0;
        for (int t = 1; t <= 9 && first_t == 0; t++) begin
            tick(1'b1, 4'h8, 4'h0);
            if (press_pulse[3]) first_t = t;
        end
        check("sticky_press_seen", 4'(first_t), 4'd6);
        tick(1'b1, 4'h8, 4'h8);
        check("sticky_set_wins", buttons_out, 4'h8);
        for (int t = 0; t < 8; t++) tick(1'b1, 4'h0, 4'hF);
`endif

        // randomized traffic against the model
        r = '0;
        for (int t = 0; t < 800; t++) begin
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            tick(($urandom_range(0, 99) != 0), r, 4'($urandom) & 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
